// File: rtl/i2c_slave.sv
// I2C responder: 7-bit address match, multi-byte write and read.
// SCL/SDA oversampled on the system clock; SDA driven open-drain.
module i2c_slave #(
   parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       scl,
   inout  wire        sda,
   input  logic [7:0] tx_data,
   output logic       tx_load,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       busy
);

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      ADDR_ACK,
      WR_DATA,
      WR_ACK,
      RD_DATA,
      RD_ACK,
      WAIT_STOP
   } state_t;

   logic       scl_s1_q, scl_s2_q, scl_p_q;
   logic       sda_s1_q, sda_s2_q, sda_p_q;
   state_t     state_q;
   logic [2:0] cnt_q;
   logic [7:0] shift_q;
   logic       rw_q;
   logic       phase_q;
   logic       lead_q;
   logic       sda_oe_q;
   logic       busy_q;
   logic [7:0] rx_data_q;
   logic       rx_valid_q;
   logic       tx_load_q;

   logic       scl_rise;
   logic       scl_fall;
   logic       start_det;
   logic       stop_det;
   logic [7:0] shift_d;

   assign scl_rise  = scl_s2_q & ~scl_p_q;
   assign scl_fall  = ~scl_s2_q & scl_p_q;
   assign start_det = scl_s2_q & sda_p_q & ~sda_s2_q;
   assign stop_det  = scl_s2_q & ~sda_p_q & sda_s2_q;
   assign shift_d   = {shift_q[6:0], sda_s2_q};

   assign sda      = sda_oe_q ? 1'b0 : 1'bz;
   assign tx_load  = tx_load_q;
   assign rx_data  = rx_data_q;
   assign rx_valid = rx_valid_q;
   assign busy     = busy_q;

   // Bring bus pins into the clock domain and keep one sample of history.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         scl_s1_q <= 1'b1;
         scl_s2_q <= 1'b1;
         scl_p_q  <= 1'b1;
         sda_s1_q <= 1'b1;
         sda_s2_q <= 1'b1;
         sda_p_q  <= 1'b1;
      end else begin
         scl_s1_q <= scl;
         scl_s2_q <= scl_s1_q;
         scl_p_q  <= scl_s2_q;
         sda_s1_q <= sda;
         sda_s2_q <= sda_s1_q;
         sda_p_q  <= sda_s2_q;
      end
   end

   // Protocol FSM; START/STOP override whatever phase is in progress.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         cnt_q      <= 3'd0;
         shift_q    <= 8'h00;
         rw_q       <= 1'b0;
         phase_q    <= 1'b0;
         lead_q     <= 1'b0;
         sda_oe_q   <= 1'b0;
         busy_q     <= 1'b0;
         rx_data_q  <= 8'h00;
         rx_valid_q <= 1'b0;
         tx_load_q  <= 1'b0;
      end else begin
         rx_valid_q <= 1'b0;
         tx_load_q  <= 1'b0;
         if (start_det) begin
            state_q  <= ADDR;
            cnt_q    <= 3'd0;
            phase_q  <= 1'b0;
            sda_oe_q <= 1'b0;
         end else if (stop_det) begin
            state_q  <= IDLE;
            sda_oe_q <= 1'b0;
            busy_q   <= 1'b0;
         end else begin
            unique case (state_q)
               IDLE: begin
               end
               ADDR: begin
                  if (scl_rise) begin
                     shift_q <= shift_d;
                     cnt_q   <= cnt_q + 3'd1;
                     if (cnt_q == 3'd7) begin
                        if (shift_d[7:1] == SLAVE_ADDR) begin
                           rw_q    <= shift_d[0];
                           phase_q <= 1'b0;
                           state_q <= ADDR_ACK;
                        end else begin
                           busy_q  <= 1'b0;
                           state_q <= WAIT_STOP;
                        end
                     end
                  end
               end
               ADDR_ACK: begin
                  if (scl_fall) begin
                     if (!phase_q) begin
                        phase_q  <= 1'b1;
                        sda_oe_q <= 1'b1;
                        busy_q   <= 1'b1;
                        if (rw_q) begin
                           tx_load_q <= 1'b1;
                           shift_q   <= tx_data;
                        end
                     end else begin
                        phase_q <= 1'b0;
                        cnt_q   <= 3'd0;
                        if (rw_q) begin
                           sda_oe_q <= ~shift_q[7];
                           lead_q   <= 1'b0;
                           state_q  <= RD_DATA;
                        end else begin
                           sda_oe_q <= 1'b0;
                           state_q  <= WR_DATA;
                        end
                     end
                  end
               end
               WR_DATA: begin
                  if (scl_rise) begin
                     shift_q <= shift_d;
                     cnt_q   <= cnt_q + 3'd1;
                     if (cnt_q == 3'd7) begin
                        rx_data_q  <= shift_d;
                        rx_valid_q <= 1'b1;
                        phase_q    <= 1'b0;
                        state_q    <= WR_ACK;
                     end
                  end
               end
               WR_ACK: begin
                  if (scl_fall) begin
                     if (!phase_q) begin
                        phase_q  <= 1'b1;
                        sda_oe_q <= 1'b1;
                     end else begin
                        phase_q  <= 1'b0;
                        sda_oe_q <= 1'b0;
                        cnt_q    <= 3'd0;
                        state_q  <= WR_DATA;
                     end
                  end
               end
               RD_DATA: begin
                  if (scl_fall) begin
                     if (lead_q) begin
                        sda_oe_q <= ~shift_q[7];
                        lead_q   <= 1'b0;
                     end else if (cnt_q == 3'd7) begin
                        sda_oe_q <= 1'b0;
                        state_q  <= RD_ACK;
                     end else begin
                        sda_oe_q <= ~shift_q[6];
                        shift_q  <= {shift_q[6:0], 1'b0};
                        cnt_q    <= cnt_q + 3'd1;
                     end
                  end
               end
               RD_ACK: begin
                  if (scl_rise) begin
                     if (!sda_s2_q) begin
                        tx_load_q <= 1'b1;
                        shift_q   <= tx_data;
                        lead_q    <= 1'b1;
                        cnt_q     <= 3'd0;
                        state_q   <= RD_DATA;
                     end else begin
                        state_q <= WAIT_STOP;
                     end
                  end
               end
               WAIT_STOP: begin
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_i2c_slave.sv
// Directed bench for i2c_slave: a bit-banged bus master drives the
// scenarios and checks ACKs, read data, strobes and busy.
module tb_i2c_slave;

   localparam int Q = 50;

   logic       clk;
   logic       rst_n;
   logic       scl_m;
   logic       sda_m_oe;
   logic [7:0] tx_data;
   logic       tx_load;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       busy;
   wire        sda_w;

   int n_checks;
   int n_fail;
   int n_rxv;
   int n_txl;
   int n_both;
   logic [7:0] rx_log[$];

   assign sda_w = sda_m_oe ? 1'b0 : 1'bz;
   pullup (sda_w);

   i2c_slave #(.SLAVE_ADDR(7'h50)) dut (
      .clock    (clk),
      .reset    (rst_n),
      .scl      (scl_m),
      .sda      (sda_w),
      .tx_data  (tx_data),
      .tx_load  (tx_load),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .busy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count strobes and log written bytes, sampled off the active edge.
   always @(negedge clk) begin
      if (rx_valid) begin
         n_rxv++;
         rx_log.push_back(rx_data);
      end
      if (tx_load) n_txl++;
      if (rx_valid && tx_load) n_both++;
   end

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic bus_start();
      sda_m_oe = 1'b1; #Q;
      scl_m = 1'b0; #Q;
   endtask

   task automatic bus_rstart();
      sda_m_oe = 1'b0; #Q;
      scl_m = 1'b1; #Q;
      sda_m_oe = 1'b1; #Q;
      scl_m = 1'b0; #Q;
   endtask

   task automatic bus_stop();
      sda_m_oe = 1'b1; #Q;
      scl_m = 1'b1; #Q;
      sda_m_oe = 1'b0; #(2*Q);
   endtask

   task automatic bit_xfer(input logic b, output logic s);
      sda_m_oe = ~b; #Q;
      scl_m = 1'b1; #Q;
      s = sda_w; #Q;
      scl_m = 1'b0; #Q;
   endtask

   task automatic wr_byte(input logic [7:0] d, output logic ack);
      logic s;
      for (int i = 7; i >= 0; i--) bit_xfer(d[i], s);
      bit_xfer(1'b1, ack);
   endtask

   task automatic rd_byte(input logic mack, output logic [7:0] d);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         bit_xfer(1'b1, s);
         d[i] = s;
      end
      bit_xfer(mack, s);
   endtask

   initial begin
      logic       ack;
      logic       s;
      logic [7:0] d;
      logic [7:0] burst [3];
      burst[0] = 8'h11;
      burst[1] = 8'h22;
      burst[2] = 8'h33;
      n_checks = 0;
      n_fail   = 0;
      n_rxv    = 0;
      n_txl    = 0;
      n_both   = 0;
      rst_n    = 1'b0;
      scl_m    = 1'b1;
      sda_m_oe = 1'b0;
      tx_data  = 8'h00;
      #(4*Q);

      check("rst_busy", busy, 0);
      check("rst_rxv", rx_valid, 0);
      check("rst_txl", tx_load, 0);
      check("rst_rxd", rx_data, 8'h00);
      check("rst_sda", sda_w, 1);
      rst_n = 1'b1;
      #(2*Q);

      bus_start();
      wr_byte(8'hA0, ack);
      check("w1_addr_ack", ack, 0);
      check("w1_busy", busy, 1);
      wr_byte(8'h3C, ack);
      check("w1_data_ack", ack, 0);
      bus_stop();
      check("w1_rxd", rx_data, 8'h3C);
      check("w1_nrxv", n_rxv, 1);
      check("w1_busy_off", busy, 0);
      check("w1_ntxl", n_txl, 0);

      bus_start();
      wr_byte(8'hA0, ack);
      check("wb_addr_ack", ack, 0);
      for (int i = 0; i < 3; i++) begin
         wr_byte(burst[i], ack);
         check("wb_ack", ack, 0);
      end
      bus_stop();
      check("wb_nrxv", n_rxv, 4);
      check("wb_b0", rx_log[1], 8'h11);
      check("wb_b1", rx_log[2], 8'h22);
      check("wb_b2", rx_log[3], 8'h33);

      tx_data = 8'h5A;
      bus_start();
      wr_byte(8'hA1, ack);
      check("rd_addr_ack", ack, 0);
      check("rd_ntxl1", n_txl, 1);
      tx_data = 8'hC3;
      rd_byte(1'b0, d);
      check("rd_byte1", d, 8'h5A);
      check("rd_ntxl2", n_txl, 2);
      rd_byte(1'b1, d);
      check("rd_byte2", d, 8'hC3);
      check("rd_ntxl_nack", n_txl, 2);
      check("rd_sda_rel", sda_w, 1);
      check("rd_busy_wait", busy, 1);
      bus_stop();
      check("rd_busy_off", busy, 0);
      check("rd_nrxv", n_rxv, 4);

      bus_start();
      wr_byte(8'hA2, ack);
      check("mm_addr_nack", ack, 1);
      check("mm_busy", busy, 0);
      wr_byte(8'h00, ack);
      check("mm_data_nack", ack, 1);
      bus_stop();
      check("mm_nrxv", n_rxv, 4);
      check("mm_ntxl", n_txl, 2);

      bus_start();
      wr_byte(8'hA0, ack);
      check("sr_waddr_ack", ack, 0);
      wr_byte(8'h07, ack);
      check("sr_wdata_ack", ack, 0);
      tx_data = 8'h99;
      bus_rstart();
      check("sr_busy_held", busy, 1);
      wr_byte(8'hA1, ack);
      check("sr_raddr_ack", ack, 0);
      rd_byte(1'b1, d);
      check("sr_rdata", d, 8'h99);
      bus_stop();
      check("sr_rxd", rx_data, 8'h07);
      check("sr_nrxv", n_rxv, 5);
      check("sr_ntxl", n_txl, 3);

      tx_data = 8'h00;
      bus_start();
      wr_byte(8'hA1, ack);
      check("rr_addr_ack", ack, 0);
      for (int i = 0; i < 3; i++) bit_xfer(1'b1, s);
      sda_m_oe = 1'b0; #Q;
      scl_m = 1'b1; #Q;
      check("rr_sda_driven", sda_w, 0);
      rst_n = 1'b0;
      #1;
      check("rr_sda_rel", sda_w, 1);
      check("rr_busy", busy, 0);
      check("rr_rxd", rx_data, 8'h00);
      check("rr_rxv", rx_valid, 0);
      check("rr_txl", tx_load, 0);
      #(Q-1);
      scl_m = 1'b0; #Q;
      rst_n = 1'b1; #Q;
      bus_stop();
      bus_start();
      wr_byte(8'hA0, ack);
      check("rr_re_ack", ack, 0);
      wr_byte(8'h5E, ack);
      check("rr_re_dack", ack, 0);
      bus_stop();
      check("rr_re_rxd", rx_data, 8'h5E);
      check("rr_re_nrxv", n_rxv, 6);
      check("no_overlap", n_both, 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
